core_boot_sequencer: RTL

//  Drives the control side of RISC_V_Core: reset, start, prog_address and report.
//  On a boot request it holds the core in reset, pulses start with a latched program address,

---
 rtl/core_boot_sequencer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/core_boot_sequencer.sv
// Boot controller for a RISC-V core: hold in reset, pulse start with a latched address, count run cycles to halt, then report.
// Optional macro BOOT_TIMEOUT_EN ends the run after RUN_CYCLES cycles and flags timeout; otherwise timeout is tied low.
module core_boot_sequencer #(
    parameter int ADDRESS_BITS = 20,
    parameter int RESET_CYCLES = 4,
    parameter int START_CYCLES = 1,
    parameter int RUN_CYCLES   = 150,
    parameter int COUNT_BITS   = 32
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic                    boot_req_i,
    input  logic [ADDRESS_BITS-1:0] boot_address_i,
    input  logic                    core_halt_i,
    output logic                    core_reset_o,
    output logic                    core_start_o,
    output logic [ADDRESS_BITS-1:0] core_prog_address_o,
    output logic                    core_report_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    timeout_o,
    output logic [COUNT_BITS-1:0]   cycle_count_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_HOLD, S_START, S_RUN, S_REPORT, S_DONE
    } state_t;

    localparam int PH_MAX  = (RESET_CYCLES > START_CYCLES) ? RESET_CYCLES : START_CYCLES;
    localparam int PH_BITS = $clog2(PH_MAX + 1);
    localparam logic [COUNT_BITS-1:0] LIMIT = COUNT_BITS'(RUN_CYCLES - 1);

`ifdef BOOT_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    state_t                  state_q;
    logic [PH_BITS-1:0]      phase_q;
    logic                    core_reset_q;
    logic                    core_start_q;
    logic [ADDRESS_BITS-1:0] addr_q;
    logic                    core_report_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    timeout_q;
    logic [COUNT_BITS-1:0]   cycle_count_q;
    logic [COUNT_BITS-1:0]   cycle_count_d;

    // Saturating run-cycle increment.
    assign cycle_count_d = (&cycle_count_q) ? cycle_count_q : cycle_count_q + COUNT_BITS'(1);

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q       <= S_IDLE;
            phase_q       <= '0;
            core_reset_q  <= 1'b1;
            core_start_q  <= 1'b0;
            addr_q        <= '0;
            core_report_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
            cycle_count_q <= '0;
        end else begin
            core_report_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (boot_req_i) begin
                        state_q       <= S_HOLD;
                        addr_q        <= boot_address_i;
                        cycle_count_q <= '0;
                        timeout_q     <= 1'b0;
                        phase_q       <= '0;
                        core_reset_q  <= 1'b1;
                        busy_q        <= 1'b1;
                        done_q        <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (phase_q == PH_BITS'(RESET_CYCLES - 1)) begin
                        state_q      <= S_START;
                        phase_q      <= '0;
                        core_reset_q <= 1'b0;
                        core_start_q <= 1'b1;
                    end else begin
                        phase_q <= phase_q + PH_BITS'(1);
                    end
                end
                S_START: begin
                    if (phase_q == PH_BITS'(START_CYCLES - 1)) begin
                        state_q      <= S_RUN;
                        phase_q      <= '0;
                        core_start_q <= 1'b0;
                    end else begin
                        phase_q <= phase_q + PH_BITS'(1);
                    end
                end
                S_RUN: begin
                    // Halt takes priority over the cycle limit; the halting cycle is not counted.
                    if (core_halt_i) begin
                        state_q       <= S_REPORT;
                        core_report_q <= 1'b1;
                    end else begin
                        cycle_count_q <= cycle_count_d;
                        if (TIMEOUT_EN && (cycle_count_q == LIMIT)) begin
                            state_q       <= S_REPORT;
                            core_report_q <= 1'b1;
                            timeout_q     <= 1'b1;
                        end
                    end
                end
                S_REPORT: begin
                    state_q <= S_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q      <= S_IDLE;
                    core_reset_q <= 1'b1;
                    core_start_q <= 1'b0;
                    busy_q       <= 1'b0;
                    done_q       <= 1'b0;
                end
            endcase
        end
    end

    assign core_reset_o        = core_reset_q;
    assign core_start_o        = core_start_q;
    assign core_prog_address_o = addr_q;
    assign core_report_o       = core_report_q;
    assign busy_o              = busy_q;
    assign done_o              = done_q;
    assign timeout_o           = timeout_q;
    assign cycle_count_o       = cycle_count_q;

endmodule
